// File: rtl/aes_core_serial_dec.sv
// Serial AES-128 decryption core: on-the-fly key expansion to round key 10, then
// inverse rounds processed one column per cycle with the key schedule run backwards.
module aes_core_serial_dec (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] data_in,
  input  logic [127:0] key_in,
  output logic [127:0] data_out,
  output logic         ready
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_KEXP,
    S_INIT,
    S_SHIFT,
    S_COL
  } state_t;

  // ---------------------------------------------------------------------------
  // GF(2^8) helpers, polynomial 0x11b
  // ---------------------------------------------------------------------------
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = xtime(t);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (maps 0 to 0, as the S-box requires).
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 7; i >= 0; i--) begin
      r = gf_mul(r, r);
      if (i != 0) r = gf_mul(r, a);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^
           {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    logic [7:0] t;
    t = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
    return gf_inv(t);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    logic [7:0] r;
    case (idx)
      4'd0:    r = 8'h01;
      4'd1:    r = 8'h02;
      4'd2:    r = 8'h04;
      4'd3:    r = 8'h08;
      4'd4:    r = 8'h10;
      4'd5:    r = 8'h20;
      4'd6:    r = 8'h40;
      4'd7:    r = 8'h80;
      4'd8:    r = 8'h1b;
      4'd9:    r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
            gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
            gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
            gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
  endfunction

  // Row r rotates right by r: out[r][c] = in[r][(c - r) mod 4]. Pure wiring.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127 - 8 * (r + 4 * c) -: 8] = s[127 - 8 * (r + 4 * ((c - r + 4) % 4)) -: 8];
      end
    end
    return o;
  endfunction

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_t         state_q, state_d;
  logic [127:0]   st_q, st_d;
  logic [127:0]   key_q, key_d;
  logic [3:0]     round_q, round_d;
  logic [1:0]     col_q, col_d;
  logic [127:0]   dout_d;

  assign ready = (state_q == S_IDLE);

  // ---------------------------------------------------------------------------
  // Key schedule: one shared 4-S-box word path serves forward and backward steps
  // ---------------------------------------------------------------------------
  logic [31:0] kw0, kw1, kw2, kw3;
  logic [31:0] ks_word, ks_rot, ks_temp;
  logic [31:0] f0, f1, f2, f3;
  logic [31:0] p0, p1, p2, p3;
  logic [127:0] fwd_key, prev_key;

  assign {kw0, kw1, kw2, kw3} = key_q;

  // Going backwards, the previous w3 is recovered first and fed to the S-boxes.
  assign ks_word = (state_q == S_KEXP) ? kw3 : (kw3 ^ kw2);
  assign ks_rot  = {ks_word[23:0], ks_word[31:24]};
  assign ks_temp = {sbox(ks_rot[31:24]), sbox(ks_rot[23:16]),
                    sbox(ks_rot[15:8]),  sbox(ks_rot[7:0])} ^ {rcon(round_q), 24'h0};

  assign f0 = kw0 ^ ks_temp;
  assign f1 = kw1 ^ f0;
  assign f2 = kw2 ^ f1;
  assign f3 = kw3 ^ f2;
  assign fwd_key = {f0, f1, f2, f3};

  assign p3 = kw3 ^ kw2;
  assign p2 = kw2 ^ kw1;
  assign p1 = kw1 ^ kw0;
  assign p0 = kw0 ^ ks_temp;
  assign prev_key = {p0, p1, p2, p3};

  // ---------------------------------------------------------------------------
  // Column datapath: InvSubBytes -> AddRoundKey -> InvMixColumns (skipped in round 0)
  // ---------------------------------------------------------------------------
  logic [31:0]  col_in, col_key, col_isb, col_ark, col_out;
  logic [127:0] st_col_wr;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    col_in  = st_q[127:96];
    col_key = key_q[127:96];
    case (col_q)
      2'd0: begin col_in = st_q[127:96]; col_key = key_q[127:96]; end
      2'd1: begin col_in = st_q[95:64];  col_key = key_q[95:64];  end
      2'd2: begin col_in = st_q[63:32];  col_key = key_q[63:32];  end
      default: begin col_in = st_q[31:0]; col_key = key_q[31:0]; end
    endcase
  end

  assign col_isb = {inv_sbox(col_in[31:24]), inv_sbox(col_in[23:16]),
                    inv_sbox(col_in[15:8]),  inv_sbox(col_in[7:0])};
  assign col_ark = col_isb ^ col_key;
  assign col_out = (round_q == 4'd0) ? col_ark : inv_mix_col(col_ark);

  always_comb begin
    st_col_wr = st_q;
    case (col_q)
      2'd0:    st_col_wr[127:96] = col_out;
      2'd1:    st_col_wr[95:64]  = col_out;
      2'd2:    st_col_wr[63:32]  = col_out;
      default: st_col_wr[31:0]   = col_out;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Next-state / datapath control
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    st_d    = st_q;
    key_d   = key_q;
    round_d = round_q;
    col_d   = col_q;
    dout_d  = data_out;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          st_d    = data_in;
          key_d   = key_in;
          round_d = 4'd0;
          col_d   = 2'd0;
          state_d = S_KEXP;
        end
      end
      S_KEXP: begin
        key_d = fwd_key;
        if (round_q == 4'd9) state_d = S_INIT;
        else                 round_d = round_q + 4'd1;
      end
      S_INIT: begin
        st_d    = st_q ^ key_q;
        round_d = 4'd9;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        st_d    = inv_shift_rows(st_q);
        key_d   = prev_key;
        col_d   = 2'd0;
        state_d = S_COL;
      end
      S_COL: begin
        st_d  = st_col_wr;
        col_d = col_q + 2'd1;
        if (col_q == 2'd3) begin
          if (round_q != 4'd0) begin
            round_d = round_q - 4'd1;
            state_d = S_SHIFT;
          end else begin
            dout_d  = st_col_wr;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      st_q     <= '0;
      key_q    <= '0;
      round_q  <= '0;
      col_q    <= '0;
      data_out <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q  <= state_d;
      st_q     <= st_d;
      key_q    <= key_d;
      round_q  <= round_d;
      col_q    <= col_d;
      data_out <= dout_d;
    end
  end

endmodule

// File: tb/tb_aes_core_serial_dec.sv
// Scoreboard bench for aes_core_serial_dec: directed FIPS-197 vectors, busy-start,
// mid-run reset and back-to-back cases; a monitor checks each completion.
module tb_aes_core_serial_dec;

  logic         clk;
  logic         rst;
  logic         start;
  logic [127:0] data_in;
  logic [127:0] key_in;
  logic [127:0] data_out;
  logic         ready;

  aes_core_serial_dec dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .data_in  (data_in),
    .key_in   (key_in),
    .data_out (data_out),
    .ready    (ready)
  );

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] Z_CT   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
  localparam int           LAT    = 61;

  typedef struct {
    logic [127:0] pt;
    int           cyc;
  } exp_t;

  exp_t         sb_q[$];
  int           n_cmp = 0;
  int           n_fail = 0;
  int           cyc = 0;
  int           last_acc = 0;
  logic         prev_ready = 1'b1;
  logic [127:0] prev_dout = '0;
  logic         dout_changed = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: a rising ready outside reset is a completion; pop and compare.
  always @(negedge clk) begin
    if (rst) begin
      dout_changed = 1'b0;
    end else if (ready && !prev_ready) begin
      if (sb_q.size() == 0) begin
        check("unexpected_completion", sb_q.size(), 1);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("plaintext", data_out, e.pt);
        check("latency_cycle", cyc, e.cyc);
        check("dout_stable_between", dout_changed, 1'b0);
      end
      dout_changed = 1'b0;
    end else if (data_out !== prev_dout) begin
      dout_changed = 1'b1;
    end
    prev_ready = ready;
    prev_dout  = data_out;
  end

  // Called at a negedge with ready=1; accept happens on the next rising edge.
  task automatic issue(input logic [127:0] key, input logic [127:0] ct, input logic [127:0] pt);
    exp_t e;
    start   = 1'b1;
    data_in = ct;
    key_in  = key;
    @(posedge clk);
    #1;
    last_acc = cyc;
    start    = 1'b0;
    data_in  = ~ct;
    key_in   = ~key;
    e.pt  = pt;
    e.cyc = last_acc + LAT;
    sb_q.push_back(e);
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while ((sb_q.size() != 0 || !ready) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("done_within_budget", n < budget, 1'b1);
    @(negedge clk);
  endtask

  initial begin
    int e0;
    exp_t e;
    rst     = 1'b1;
    start   = 1'b0;
    data_in = '0;
    key_in  = '0;
    repeat (3) @(negedge clk);
    check("reset_ready", ready, 1'b1);
    check("reset_dout", data_out, '0);
    rst = 1'b0;
    @(negedge clk);

    issue(C1_KEY, C1_CT, C1_PT);
    wait_done(150);
    issue(B_KEY, B_CT, B_PT);
    wait_done(150);
    issue('0, Z_CT, '0);
    wait_done(150);

    // Start pulsed while busy must be ignored.
    issue(C1_KEY, C1_CT, C1_PT);
    while (cyc < last_acc + 20) @(negedge clk);
    start   = 1'b1;
    data_in = B_CT;
    key_in  = B_KEY;
    @(negedge clk);
    start = 1'b0;
    wait_done(150);

    // Reset mid-run: immediate clear, aborted result never appears.
    issue(C1_KEY, C1_CT, C1_PT);
    while (cyc < last_acc + 30) @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midrun_reset_ready", ready, 1'b1);
    check("midrun_reset_dout", data_out, '0);
    sb_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    issue(B_KEY, B_CT, B_PT);
    wait_done(150);

    // Back-to-back with start held high: completions 62 cycles apart.
    start   = 1'b1;
    data_in = C1_CT;
    key_in  = C1_KEY;
    @(posedge clk);
    #1;
    e0      = cyc;
    data_in = B_CT;
    key_in  = B_KEY;
    e.pt  = C1_PT;
    e.cyc = e0 + LAT;
    sb_q.push_back(e);
    e.pt  = B_PT;
    e.cyc = e0 + LAT + 1 + LAT;
    sb_q.push_back(e);
    while (cyc < e0 + LAT + 1) begin
      @(posedge clk);
      #1;
    end
    start   = 1'b0;
    data_in = '0;
    key_in  = '0;
    wait_done(250);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_core_serial_dec.md
AES_CORE_SERIAL_DEC -- requirements
Module: aes_core_serial_dec

Interface
REQ-001 The module SHALL have no parameters; the key is fixed at AES-128 and the datapath is fixed at 128 bits.
REQ-002 clk  input  1  single clock; all state updates occur on its rising edge.
REQ-003 rst  input  1  reset; asynchronous, active-high.
REQ-004 start  input  1  request to decrypt; sampled only while ready=1.
REQ-005 data_in  input  128  ciphertext; byte 0 = bits[127:120], column-major per FIPS-197.
REQ-006 key_in  input  128  cipher key, i.e. round key 0, in the same byte order.
REQ-007 data_out  output  128  plaintext result; holds its value until the next completion.
REQ-008 ready  output  1  1 = idle and able to accept start; 0 = busy.

Function
REQ-009 The block SHALL implement the FIPS-197 inverse cipher, giving the exact inverse of the team's serial encryption core for the same key.
REQ-010 The datapath SHALL use exactly 4 inverse S-box lookups for data and 4 forward S-box lookups for the key schedule, all combinational.
REQ-011 States SHALL be IDLE, KEXP, INIT, SHIFT, COL and DONE-free: the block returns directly to IDLE when the last column completes.
REQ-012 Accept: on a rising edge with state=IDLE and start=1, the block SHALL do the following.
- state register <= data_in; key register <= key_in.
- round counter <= 0; state <= KEXP.
- ready <= 0.
REQ-013 start=0 in IDLE SHALL leave all registers unchanged.
REQ-014 start=1 while busy SHALL be ignored, with no restart and no corruption.
REQ-015 data_in and key_in SHALL be sampled only at the accept edge and may change freely afterwards.
REQ-016 KEXP SHALL last 10 cycles, each advancing the key register one forward-expansion round with Rcon 01,02,04,08,10,20,40,80,1b,36; after it the key register holds round key 10.
REQ-017 INIT SHALL last 1 cycle: state <= state XOR key register; round counter <= 9.
REQ-018 SHIFT SHALL last 1 cycle and do both of the following.
- state <= InvShiftRows(state), as pure wiring.
- key register <= previous round key, derived in one cycle from the current one using Rcon[round+1] in descending order.
REQ-019 COL SHALL last 4 cycles, c = 0..3, one column per cycle.
- Column c <= InvSubBytes, then XOR the round-key column, then InvMixColumns.
- InvMixColumns SHALL be omitted when round = 0.
- Other columns SHALL be unchanged.
REQ-020 After COL c=3 the block SHALL go to SHIFT with round decremented if round > 0; otherwise it SHALL complete.
REQ-021 Completion SHALL load data_out with the final state on the same edge that writes column 3 of round 0, and set ready <= 1, state <= IDLE.
REQ-022 Latency SHALL be fixed: if start is accepted at edge E0, ready=1 and a valid data_out SHALL appear after edge E0+61 (10 KEXP + 1 INIT + 10 x (1 SHIFT + 4 COL)).
REQ-023 data_out SHALL NOT change at any edge other than a completion edge.
REQ-024 Back-to-back operation: start held high SHALL be accepted on the first edge after ready rises, giving a 62-cycle period.
REQ-025 All GF(2^8) arithmetic SHALL use the polynomial 0x11b; InvMixColumns coefficients SHALL be 0e, 0b, 0d, 09.

Reset
REQ-026 rst=1 SHALL immediately and asynchronously force the following, regardless of current state, including mid-operation:
- state = IDLE, ready = 1, data_out = 0;
- state register, key register and round/column counters = 0.
REQ-027 An in-flight operation aborted by reset SHALL produce no output.
REQ-028 The first edge after rst falls SHALL be able to accept start.

Verification
REQ-029 FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, data_in 69c4e0d86a7b0430d8cdb78070b4c55a -> data_out 00112233445566778899aabbccddeeff; ready high exactly 61 edges after the accept edge.
REQ-030 FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, data_in 3925841d02dc09fbdc118597196a0b32 -> data_out 3243f6a8885a308d313198a2e0370734.
REQ-031 All-zero key, data_in 66e94bd4ef8a2c3b884cfa59ca342b2e -> data_out 00000000000000000000000000000000.
REQ-032 Test 1 running, pulse start with the App. B vectors at cycle 20 -> ignored; test 1 result appears unchanged at cycle 61.
REQ-033 Assert rst at cycle 30 of test 1 -> ready=1 and data_out=0 immediately; a new App. B run after release gives the correct plaintext in 61 cycles.
REQ-034 start held high for two operations (C.1 then App. B) -> two correct results, completions 62 cycles apart, data_out stable between them.
